// File: rtl/if_fetch_icache.sv
// rtl/if_fetch_icache.sv - instruction fetch stage with direct-mapped icache (ICACHE_EN enables the cache)
module if_fetch_icache #(
   parameter int          INDEX_BITS = 6,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic        stall_in,
   input  logic        jump_in,
   input  logic [31:0] jump_addr_in,
   output logic        if_req_out,
   output logic [31:0] inst_addr_out,
   input  logic        inst_done_in,
   input  logic [31:0] inst_in,
   output logic        inst_valid_out,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out
);

   typedef enum logic {IDLE, FETCH} state_t;

   state_t      state, state_d;
   logic [31:0] pc, pc_d;
   logic [31:0] addr_d, inst_d, pc_out_d;
   logic        req_d, valid_d;
   logic        slot_free;
   logic        hit;
   logic [31:0] hit_data;

   // the output slot can take a new instruction when empty or being consumed now
   assign slot_free = !inst_valid_out || !stall_in;

`ifdef ICACHE_EN
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;

   logic [LINES-1:0]    line_valid;
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];
   logic [INDEX_BITS-1:0] idx, fill_idx;
   logic                fill_en;

   assign idx      = pc[INDEX_BITS+1:2];
   assign fill_idx = inst_addr_out[INDEX_BITS+1:2];
   assign hit      = line_valid[idx] && (tag_mem[idx] == pc[31:INDEX_BITS+2]);
   assign hit_data = data_mem[idx];
   // a returning word fills the line even when a redirect discards it
   assign fill_en  = rdy_in && (state == FETCH) && inst_done_in;

   // line valid bits are the only cache state that needs clearing on reset
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         line_valid <= '0;
      else if (fill_en)
         line_valid[fill_idx] <= 1'b1;
   end

   // tag and data storage written on fill
   always_ff @(posedge clk_in) begin
      if (fill_en) begin
         tag_mem[fill_idx]  <= inst_addr_out[31:INDEX_BITS+2];
         data_mem[fill_idx] <= inst_in;
      end
   end
`else
   // no storage: every lookup misses and fills are dropped
   assign hit      = 1'b0;
   assign hit_data = 32'h0;
`endif

   // next-state and next-output logic; redirect overrides everything
   always_comb begin
      state_d  = state;
      pc_d     = pc;
      req_d    = if_req_out;
      addr_d   = inst_addr_out;
      valid_d  = inst_valid_out;
      inst_d   = inst_out;
      pc_out_d = pc_out;
      if (rdy_in) begin
         if (jump_in) begin
            pc_d    = jump_addr_in;
            valid_d = 1'b0;
            req_d   = 1'b0;
            state_d = IDLE;
         end else begin
            if (inst_valid_out && !stall_in)
               valid_d = 1'b0;
            case (state)
               IDLE: begin
                  if (slot_free) begin
                     if (hit) begin
                        valid_d  = 1'b1;
                        inst_d   = hit_data;
                        pc_out_d = pc;
                        pc_d     = pc + 32'd4;
                     end else begin
                        req_d   = 1'b1;
                        addr_d  = {pc[31:2], 2'b00};
                        state_d = FETCH;
                     end
                  end
               end
               FETCH: begin
                  if (inst_done_in) begin
                     req_d   = 1'b0;
                     state_d = IDLE;
                     if (slot_free) begin
                        valid_d  = 1'b1;
                        inst_d   = inst_in;
                        pc_out_d = pc;
                        pc_d     = pc + 32'd4;
                     end
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // state register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         state <= IDLE;
      else
         state <= state_d;
   end

   // pc and registered outputs
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pc             <= RESET_PC;
         if_req_out     <= 1'b0;
         inst_addr_out  <= 32'h0;
         inst_valid_out <= 1'b0;
         inst_out       <= 32'h0;
         pc_out         <= 32'h0;
      end else begin
         pc             <= pc_d;
         if_req_out     <= req_d;
         inst_addr_out  <= addr_d;
         inst_valid_out <= valid_d;
         inst_out       <= inst_d;
         pc_out         <= pc_out_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_icache.sv
// tb/tb_if_fetch_icache.sv - directed bench for if_fetch_icache (both ICACHE_EN builds)
module tb_if_fetch_icache;

`ifdef ICACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        rdy_in;
   logic        stall_in;
   logic        jump_in;
   logic [31:0] jump_addr_in;
   logic        if_req_out;
   logic [31:0] inst_addr_out;
   logic        inst_done_in;
   logic [31:0] inst_in;
   logic        inst_valid_out;
   logic [31:0] inst_out;
   logic [31:0] pc_out;

   int npass = 0;
   int ntot  = 0;

   if_fetch_icache #(.INDEX_BITS(6), .RESET_PC(32'h0)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .stall_in(stall_in),
      .jump_in(jump_in), .jump_addr_in(jump_addr_in),
      .if_req_out(if_req_out), .inst_addr_out(inst_addr_out),
      .inst_done_in(inst_done_in), .inst_in(inst_in),
      .inst_valid_out(inst_valid_out), .inst_out(inst_out), .pc_out(pc_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0000_0013 : (32'hA500_0000 ^ a);
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic do_jump(input logic [31:0] target);
      jump_in = 1'b1;
      jump_addr_in = target;
      tick();
      jump_in = 1'b0;
      chk("jump_valid", {31'h0, inst_valid_out}, 32'd0);
      chk("jump_req", {31'h0, if_req_out}, 32'd0);
   endtask

   // serve requests until one instruction appears; check it and its latency
   task automatic fetch_one(input string tag, input logic [31:0] exp_pc, input bit exp_hit);
      bit   got = 1'b0;
      bit   saw = 1'b0;
      int   cycles = 0;
      bit   miss;
      miss = !CACHE || !exp_hit;
      for (int i = 0; i < 20 && !got; i++) begin
         inst_done_in = 1'b0;
         if (if_req_out) begin
            saw = 1'b1;
            chk({tag, "_addr"}, inst_addr_out, exp_pc);
            inst_done_in = 1'b1;
            inst_in = mem_word(inst_addr_out);
         end
         tick();
         inst_done_in = 1'b0;
         cycles++;
         if (inst_valid_out) got = 1'b1;
      end
      chk({tag, "_got"}, {31'h0, got}, 32'd1);
      chk({tag, "_pc"}, pc_out, exp_pc);
      chk({tag, "_inst"}, inst_out, mem_word(exp_pc));
      chk({tag, "_req"}, {31'h0, saw}, {31'h0, miss});
      chk({tag, "_cyc"}, cycles, miss ? 32'd2 : 32'd1);
   endtask

   initial begin
      rst_n_in = 1'b0; rdy_in = 1'b1; stall_in = 1'b0; jump_in = 1'b0;
      jump_addr_in = 32'h0; inst_done_in = 1'b0; inst_in = 32'h0;
      tick(); tick();
      chk("rst_req", {31'h0, if_req_out}, 32'd0);
      chk("rst_addr", inst_addr_out, 32'd0);
      chk("rst_valid", {31'h0, inst_valid_out}, 32'd0);
      chk("rst_inst", inst_out, 32'd0);
      chk("rst_pc", pc_out, 32'd0);
      rst_n_in = 1'b1;

      // cold start, then redirect while 0x8 is outstanding (its word arrives the same cycle)
      fetch_one("f0", 32'h0, 1'b0);
      fetch_one("f4", 32'h4, 1'b0);
      tick();
      chk("f8_req", {31'h0, if_req_out}, 32'd1);
      chk("f8_addr", inst_addr_out, 32'h8);
      chk("f8_valid", {31'h0, inst_valid_out}, 32'd0);
      inst_done_in = 1'b1;
      inst_in = mem_word(32'h8);
      do_jump(32'h100);
      inst_done_in = 1'b0;
      fetch_one("f100", 32'h100, 1'b0);

      // 0x100 evicted 0x0; 0x8 was filled by the discarded return
      do_jump(32'h0);
      fetch_one("a0", 32'h0, 1'b0);
      fetch_one("a4", 32'h4, 1'b1);
      fetch_one("a8", 32'h8, 1'b1);
      fetch_one("aC", 32'hC, 1'b0);

      // second pass over the loop
      do_jump(32'h0);
      fetch_one("b0", 32'h0, 1'b1);
      fetch_one("b4", 32'h4, 1'b1);
      fetch_one("b8", 32'h8, 1'b1);
      fetch_one("bC", 32'hC, 1'b1);

      // stall holds the slot
      stall_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", {31'h0, inst_valid_out}, 32'd1);
         chk("stall_pc", pc_out, 32'hC);
         chk("stall_inst", inst_out, mem_word(32'hC));
      end
      stall_in = 1'b0;
      fetch_one("s10", 32'h10, 1'b0);

      // rdy low freezes, and a return during the freeze is lost
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("frz_valid", {31'h0, inst_valid_out}, 32'd1);
         chk("frz_pc", pc_out, 32'h10);
         chk("frz_req", {31'h0, if_req_out}, 32'd0);
      end
      rdy_in = 1'b1;
      tick();
      chk("r14_req", {31'h0, if_req_out}, 32'd1);
      chk("r14_addr", inst_addr_out, 32'h14);
      rdy_in = 1'b0;
      inst_done_in = 1'b1;
      inst_in = mem_word(32'h14);
      tick();
      inst_done_in = 1'b0;
      rdy_in = 1'b1;
      chk("lost_req", {31'h0, if_req_out}, 32'd1);
      chk("lost_valid", {31'h0, inst_valid_out}, 32'd0);
      inst_done_in = 1'b1;
      tick();
      inst_done_in = 1'b0;
      chk("r14_valid", {31'h0, inst_valid_out}, 32'd1);
      chk("r14_pc", pc_out, 32'h14);
      chk("r14_inst", inst_out, mem_word(32'h14));

      // pc wraps past the top of the address space
      do_jump(32'hFFFF_FFFC);
      fetch_one("wtop", 32'hFFFF_FFFC, 1'b0);
      fetch_one("wrap", 32'h0, 1'b1);

      // async reset during an outstanding fetch
      do_jump(32'h200);
      tick();
      chk("m200_req", {31'h0, if_req_out}, 32'd1);
      chk("m200_addr", inst_addr_out, 32'h200);
      #2;
      rst_n_in = 1'b0;
      #1;
      chk("arst_req", {31'h0, if_req_out}, 32'd0);
      chk("arst_addr", inst_addr_out, 32'd0);
      chk("arst_valid", {31'h0, inst_valid_out}, 32'd0);
      chk("arst_pc", pc_out, 32'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
